// File: rtl/tt_pin_conditioner.sv
// rtl/tt_pin_conditioner.sv - synchronise, debounce and edge-detect raw input pins
//
// Parameters:
//   NCH         number of input channels (1..16)
//   SYNC_STAGES synchroniser depth (>=2)
//   DEB_CYCLES  enabled cycles a new level must persist before it is accepted (>=1)
//   RESET_VAL   reset level of every synchroniser flop and stable bit
// Optional feature macro: TT_PIN_EVT_LATCH_EN (sticky per-channel event flags)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        design enable; low freezes debounce state and suppresses events
//   pin_i      raw asynchronous pin levels
//   stable_o   debounced level per channel
//   rise_o     one-cycle pulse when stable_o goes 0->1
//   fall_o     one-cycle pulse when stable_o goes 1->0
//   evt_clr_i  clears sticky event flags (ignored without TT_PIN_EVT_LATCH_EN)
//   evt_o      sticky event flags (tied low without TT_PIN_EVT_LATCH_EN)
module tt_pin_conditioner #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [NCH-1:0] pin_i,
  output logic [NCH-1:0] stable_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  input  logic [NCH-1:0] evt_clr_i,
  output logic [NCH-1:0] evt_o
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [NCH-1:0] RST_VEC = {NCH{RESET_VAL}};

  // Synchroniser: stage 0 samples the pin, the last stage feeds the debouncer.
  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VEC}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  // Debounce state
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         stable_q, stable_d;
  logic [NCH-1:0]         rise_q, rise_d;
  logic [NCH-1:0]         fall_q, fall_d;

  // The counter counts consecutive mismatching cycles; reaching CNT_LAST with
  // one more mismatch accepts the new level, so it never exceeds CNT_LAST.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    if (ena) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (s[ch] == stable_q[ch]) begin
          cnt_d[ch] = '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          cnt_d[ch]    = '0;
          stable_d[ch] = s[ch];
          rise_d[ch]   = s[ch];
          fall_d[ch]   = ~s[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= RST_VEC;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

`ifdef TT_PIN_EVT_LATCH_EN
  logic [NCH-1:0] evt_q, evt_d;

  // A new event takes priority over a coincident clear.
  always_comb begin
    evt_d = evt_q;
    if (ena) begin
      evt_d = (evt_q & ~evt_clr_i) | rise_d | fall_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_o = evt_q;
`else
  logic unused_evt_clr;

  assign unused_evt_clr = ^evt_clr_i;
  assign evt_o          = '0;
`endif

endmodule

// File: tb/tb_tt_pin_conditioner.sv
// tb/tb_tt_pin_conditioner.sv - scoreboard bench for tt_pin_conditioner
module tb_tt_pin_conditioner;

  localparam int NCH       = 8;
  localparam int SYNC      = 2;
  localparam int DEB       = 4;
  localparam bit RESET_VAL = 1'b0;
  localparam logic [7:0] RST_VEC = {NCH{RESET_VAL}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] pin_i = '0;
  logic [7:0] evt_clr_i = '0;
  logic [7:0] stable_o, rise_o, fall_o, evt_o;

  tt_pin_conditioner #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pin_i(pin_i),
    .stable_o(stable_o), .rise_o(rise_o), .fall_o(fall_o),
    .evt_clr_i(evt_clr_i), .evt_o(evt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic [7:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model: pins travel through a delay line of SYNC entries; a
  // channel accepts its delayed level once it has disagreed with the stable
  // level on DEB consecutive enabled edges.
  logic [7:0] m_pipe[$];
  logic [7:0] m_stable, m_rise, m_fall, m_evt;
  int         m_run[8];
  logic [7:0] cur_pin;
  logic       cur_ena;
  logic [7:0] cur_clr;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe = {};
    for (int k = 0; k < SYNC; k++) m_pipe.push_back(RST_VEC);
    m_stable = RST_VEC;
    m_rise   = '0;
    m_fall   = '0;
    m_evt    = '0;
    for (int ch = 0; ch < 8; ch++) m_run[ch] = 0;
  endtask

  task automatic model_edge();
    logic [7:0] s;
    s = m_pipe.pop_front();
    m_pipe.push_back(cur_pin);
    m_rise = '0;
    m_fall = '0;
    if (cur_ena) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (s[ch] != m_stable[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_stable[ch] = s[ch];
            if (s[ch]) m_rise[ch] = 1'b1;
            else       m_fall[ch] = 1'b1;
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
    end
`ifdef TT_PIN_EVT_LATCH_EN
    if (cur_ena) m_evt = (m_evt & ~cur_clr) | m_rise | m_fall;
`else
    m_evt = '0;
`endif
  endtask

  // One clock: model the edge, optionally pulse reset between edges, then
  // drive the inputs for the next edge and queue the expected outputs.
  task automatic step(input logic [7:0] p, input logic e, input logic [7:0] c, input bit rst_pulse);
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    if (rst_pulse) begin
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
    end
    pin_i = p; ena = e; evt_clr_i = c;
    cur_pin = p; cur_ena = e; cur_clr = c;
    x.st = m_stable; x.ri = m_rise; x.fa = m_fall; x.ev = m_evt;
    exp_q.push_back(x);
  endtask

  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b1, 8'h00, 1'b0);
  endtask

  // Monitor: compares every registered output against the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("stable_o", stable_o, x.st);
        chk("rise_o", rise_o, x.ri);
        chk("fall_o", fall_o, x.fa);
        chk("evt_o", evt_o, x.ev);
        chk("rise_and_fall", rise_o & fall_o, 8'h00);
      end
    end
  end

  // Reset must act without a clock edge.
  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      chk("async_stable", stable_o, RST_VEC);
      chk("async_rise", rise_o, 8'h00);
      chk("async_fall", fall_o, 8'h00);
      chk("async_evt", evt_o, 8'h00);
    end
  end

  initial begin
    int n;
    int hold_cnt;
    logic [7:0] rp;
    logic e;
    logic [7:0] c;

    cur_pin = '0; cur_ena = 1'b1; cur_clr = '0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    pin_i = '0; ena = 1'b1; evt_clr_i = '0;
    rst_n = 1'b1;

    // 1: single rise, latency from the driving edge
    hold(8'h00, 4);
    step(8'h01, 1'b1, 8'h00, 1'b0);
    n = 0;
    while (stable_o[0] !== 1'b1 && n < 20) begin
      step(8'h01, 1'b1, 8'h00, 1'b0);
      n++;
    end
    chk("latency_edges", 8'(n), 8'(SYNC + DEB));
    hold(8'h01, 3);
    hold(8'h00, 8);

    // 2: glitch rejection and a just-long-enough pulse on ch3
    hold(8'h08, 3);
    hold(8'h00, 8);
    hold(8'h08, 4);
    hold(8'h00, 10);

    // 3: simultaneous events
    hold(8'hA5, 8);
    hold(8'h5A, 8);
    hold(8'h00, 8);

    // 4: ena freeze after two mismatch cycles on ch1
    step(8'h02, 1'b1, 8'h00, 1'b0);
    hold(8'h02, 3);
    for (int i = 0; i < 10; i++) step(8'h02, 1'b0, 8'h00, 1'b0);
    hold(8'h02, 6);
    hold(8'h00, 8);

    // 5: async reset mid-count
    hold(8'h01, 8);
    hold(8'h00, 4);
    step(8'h01, 1'b1, 8'h00, 1'b1);
    hold(8'h01, 8);
    hold(8'h00, 8);

    // 6: sticky flags: rise on ch2, clear, clear coincident with a fall
    hold(8'h04, 9);
    step(8'h04, 1'b1, 8'h04, 1'b0);
    hold(8'h04, 3);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    hold(8'h00, 4);
    step(8'h00, 1'b1, 8'h04, 1'b0);
    hold(8'h00, 4);
    step(8'h00, 1'b1, 8'h04, 1'b0);
    hold(8'h00, 2);

    // Random phase
    rp = '0;
    hold_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold_cnt == 0) begin
        rp = rp ^ 8'($urandom);
        hold_cnt = $urandom_range(1, 8);
      end
      hold_cnt--;
      e = ($urandom_range(0, 9) != 0);
      c = 8'($urandom) & 8'($urandom);
      step(rp, e, c, ($urandom_range(0, 99) == 0));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
